// File: rtl/mc_ctrl.sv
// Multicycle sequencing controller for the MIPS-subset datapath.
// Holds only the state register and the decoded instruction class.
module mc_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       inst_req,
    input  logic       inst_ack,
    output logic       data_req,
    output logic       data_wr,
    input  logic       data_ack,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] ext_ctr,
    output logic       alu_src_imm,
    output logic [2:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       wb_sel,
    output logic [2:0] state_o,
    output logic       instret,
    output logic       illegal_op
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_AND, C_OR, C_SLT,
        C_ADDIU, C_ANDI, C_ORI, C_LUI,
        C_LW, C_SW, C_BEQ, C_J, C_ILL
    } cls_t;

    state_t state;
    cls_t   cls;
    cls_t   dec_cls;

    logic [2:0] cls_alu_op;
    logic       cls_src_imm;
    logic [1:0] cls_ext;
    logic       cls_rtype;

    always_comb begin
        dec_cls = C_ILL;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   dec_cls = C_ADDU;
                    6'h23:   dec_cls = C_SUBU;
                    6'h24:   dec_cls = C_AND;
                    6'h25:   dec_cls = C_OR;
                    6'h2A:   dec_cls = C_SLT;
                    default: dec_cls = C_ILL;
                endcase
            end
            6'h09:   dec_cls = C_ADDIU;
            6'h0C:   dec_cls = C_ANDI;
            6'h0D:   dec_cls = C_ORI;
            6'h0F:   dec_cls = C_LUI;
            6'h23:   dec_cls = C_LW;
            6'h2B:   dec_cls = C_SW;
            6'h04:   dec_cls = C_BEQ;
            6'h02:   dec_cls = C_J;
            default: dec_cls = C_ILL;
        endcase
    end

    // ALU configuration implied by the latched class; shared by EX and MEM.
    always_comb begin
        cls_alu_op  = 3'b000;
        cls_src_imm = 1'b0;
        cls_ext     = 2'b01;
        cls_rtype   = 1'b0;
        case (cls)
            C_ADDU:  begin cls_alu_op = 3'b000; cls_rtype = 1'b1; end
            C_SUBU:  begin cls_alu_op = 3'b001; cls_rtype = 1'b1; end
            C_AND:   begin cls_alu_op = 3'b010; cls_rtype = 1'b1; end
            C_OR:    begin cls_alu_op = 3'b011; cls_rtype = 1'b1; end
            C_SLT:   begin cls_alu_op = 3'b100; cls_rtype = 1'b1; end
            C_ADDIU, C_LW, C_SW: cls_src_imm = 1'b1;
            C_ANDI:  begin cls_alu_op = 3'b010; cls_src_imm = 1'b1; cls_ext = 2'b00; end
            C_ORI:   begin cls_alu_op = 3'b011; cls_src_imm = 1'b1; cls_ext = 2'b00; end
            C_LUI:   begin cls_src_imm = 1'b1; cls_ext = 2'b10; end
            C_BEQ:   cls_alu_op = 3'b001;
            default: cls_alu_op = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_INIT;
            cls   <= C_ILL;
        end else begin
            case (state)
                S_INIT: state <= S_IF;
                S_IF:   if (inst_ack) state <= S_ID;
                S_ID: begin
                    cls   <= dec_cls;
                    state <= (dec_cls == C_ILL) ? S_IF : S_EX;
                end
                S_EX: begin
                    if (cls == C_BEQ || cls == C_J)     state <= S_IF;
                    else if (cls == C_LW || cls == C_SW) state <= S_MEM;
                    else                                 state <= S_WB;
                end
                S_MEM: if (data_ack) state <= (cls == C_SW) ? S_IF : S_WB;
                S_WB:  state <= S_IF;
                default: state <= S_INIT;
            endcase
        end
    end

    // Outputs are decodes of state and class; only the ack, zero and
    // illegal-decode terms reach them combinationally.
    always_comb begin
        inst_req    = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        ext_ctr     = 2'b01;
        alu_src_imm = 1'b0;
        alu_op      = 3'b000;
        reg_we      = 1'b0;
        reg_dst     = 1'b0;
        wb_sel      = 1'b0;
        instret     = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            S_INIT: ext_ctr = 2'b00;
            S_IF: begin
                inst_req = 1'b1;
                ir_we    = inst_ack;
                pc_we    = inst_ack;
            end
            S_ID: illegal_op = (dec_cls == C_ILL);
            S_EX: begin
                alu_op      = cls_alu_op;
                alu_src_imm = cls_src_imm;
                ext_ctr     = cls_ext;
                if (cls == C_BEQ) begin
                    pc_we   = zero;
                    pc_src  = 2'b01;
                    instret = 1'b1;
                end else if (cls == C_J) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'b10;
                    instret = 1'b1;
                end
            end
            S_MEM: begin
                alu_op      = cls_alu_op;
                alu_src_imm = cls_src_imm;
                ext_ctr     = cls_ext;
                data_req    = 1'b1;
                data_wr     = (cls == C_SW);
                instret     = (cls == C_SW) && data_ack;
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = cls_rtype;
                wb_sel  = (cls == C_LW);
                instret = 1'b1;
            end
            default: ext_ctr = 2'b01;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected schedules built from the
// instruction rules, replayed cycle by cycle and compared on the falling edge.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] opcode, funct;
    logic       zero, inst_ack, data_ack;
    logic       inst_req, data_req, data_wr, ir_we, pc_we;
    logic [1:0] pc_src, ext_ctr;
    logic       alu_src_imm;
    logic [2:0] alu_op;
    logic       reg_we, reg_dst, wb_sel;
    logic [2:0] state_o;
    logic       instret, illegal_op;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct(funct), .zero(zero),
        .inst_req(inst_req), .inst_ack(inst_ack), .data_req(data_req),
        .data_wr(data_wr), .data_ack(data_ack), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .ext_ctr(ext_ctr), .alu_src_imm(alu_src_imm),
        .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .state_o(state_o), .instret(instret), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic       inst_req, data_req, data_wr, ir_we, pc_we;
        logic [1:0] pc_src, ext_ctr;
        logic       alu_src_imm;
        logic [2:0] alu_op;
        logic       reg_we, reg_dst, wb_sel;
        logic [2:0] state;
        logic       instret, illegal_op;
    } out_t;

    typedef struct packed {
        logic       rstn, iack, dack, zero;
        logic [5:0] op, fn;
    } stim_t;

    typedef struct packed {
        logic       legal, rtype, lw, sw, beq, j, src_imm;
        logic [2:0] alu_op;
        logic [1:0] ext;
    } info_t;

    out_t act;
    assign act = {inst_req, data_req, data_wr, ir_we, pc_we, pc_src, ext_ctr,
                  alu_src_imm, alu_op, reg_we, reg_dst, wb_sel, state_o,
                  instret, illegal_op};

    stim_t       stim_q[$];
    logic [20:0] sexp_q[$];
    logic [20:0] exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_ret = -1;
    int ret_dut = 0;
    int ret_model = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    // Compare process: one expected vector per applied cycle.
    always @(negedge clk) begin
        logic [20:0] e;
        cyc = resetn ? cyc + 1 : 0;
        if (checking && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL cycle_vec t=%0t state=%0d: got %h expected %h",
                         $time, state_o, act, e);
            end
        end
        if (resetn === 1'b1 && instret === 1'b1) begin
            ret_dut++;
            if (first_ret < 0) first_ret = cyc;
        end
    end

    function automatic info_t dec(input logic [5:0] op, input logic [5:0] fn);
        info_t d;
        d = '0;
        d.legal = 1'b1;
        d.ext = 2'b01;
        case (op)
            6'h00: begin
                d.rtype = 1'b1;
                case (fn)
                    6'h21:   d.alu_op = 3'b000;
                    6'h23:   d.alu_op = 3'b001;
                    6'h24:   d.alu_op = 3'b010;
                    6'h25:   d.alu_op = 3'b011;
                    6'h2A:   d.alu_op = 3'b100;
                    default: d.legal = 1'b0;
                endcase
            end
            6'h09: d.src_imm = 1'b1;
            6'h0C: begin d.src_imm = 1'b1; d.alu_op = 3'b010; d.ext = 2'b00; end
            6'h0D: begin d.src_imm = 1'b1; d.alu_op = 3'b011; d.ext = 2'b00; end
            6'h0F: begin d.src_imm = 1'b1; d.ext = 2'b10; end
            6'h23: begin d.src_imm = 1'b1; d.lw = 1'b1; end
            6'h2B: begin d.src_imm = 1'b1; d.sw = 1'b1; end
            6'h04: begin d.beq = 1'b1; d.alu_op = 3'b001; end
            6'h02: d.j = 1'b1;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic out_t idle(input logic [2:0] st);
        out_t o;
        o = '0;
        o.state = st;
        o.ext_ctr = (st == 3'd0) ? 2'b00 : 2'b01;
        return o;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rstn = 1'b1;
        s.iack = 1'($urandom_range(0, 1));
        s.dack = 1'($urandom_range(0, 1));
        s.zero = 1'($urandom_range(0, 1));
        s.op   = 6'($urandom);
        s.fn   = 6'($urandom);
        return s;
    endfunction

    task automatic push(input stim_t s, input out_t e);
        stim_q.push_back(s);
        sexp_q.push_back(e);
    endtask

    // n cycles held in reset, then the single INIT cycle.
    task automatic gen_reset(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = rnd_stim();
            s.rstn = 1'b0;
            push(s, idle(3'd0));
        end
        push(rnd_stim(), idle(3'd0));
    endtask

    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int dw, input logic z,
                             output int len);
        info_t d;
        stim_t s;
        out_t  e;
        d = dec(op, fn);
        len = 0;
        for (int i = 0; i <= fw; i++) begin
            s = rnd_stim();
            s.iack = (i == fw);
            e = idle(3'd1);
            e.inst_req = 1'b1;
            e.ir_we = (i == fw);
            e.pc_we = (i == fw);
            push(s, e);
            len++;
        end
        s = rnd_stim();
        s.op = op;
        s.fn = fn;
        e = idle(3'd2);
        e.illegal_op = !d.legal;
        push(s, e);
        len++;
        if (!d.legal) return;
        s = rnd_stim();
        s.op = op;
        s.fn = fn;
        if (d.beq) s.zero = z;
        e = idle(3'd3);
        e.alu_op = d.alu_op;
        e.alu_src_imm = d.src_imm;
        e.ext_ctr = d.ext;
        if (d.beq) begin
            e.pc_we = z;
            e.pc_src = 2'b01;
            e.instret = 1'b1;
        end
        if (d.j) begin
            e.pc_we = 1'b1;
            e.pc_src = 2'b10;
            e.instret = 1'b1;
        end
        push(s, e);
        len++;
        if (d.beq || d.j) begin
            ret_model++;
            return;
        end
        if (d.lw || d.sw) begin
            for (int i = 0; i <= dw; i++) begin
                s = rnd_stim();
                s.op = op;
                s.fn = fn;
                s.dack = (i == dw);
                e = idle(3'd4);
                e.alu_op = d.alu_op;
                e.alu_src_imm = d.src_imm;
                e.ext_ctr = d.ext;
                e.data_req = 1'b1;
                e.data_wr = d.sw;
                e.instret = d.sw && (i == dw);
                push(s, e);
                len++;
            end
            if (d.sw) begin
                ret_model++;
                return;
            end
        end
        s = rnd_stim();
        s.op = op;
        s.fn = fn;
        e = idle(3'd5);
        e.reg_we = 1'b1;
        e.reg_dst = d.rtype;
        e.wb_sel = d.lw;
        e.instret = 1'b1;
        push(s, e);
        len++;
        ret_model++;
    endtask

    task automatic run_queue();
        stim_t s;
        checking = 1'b1;
        while (stim_q.size() > 0) begin
            @(posedge clk);
            #1;
            s = stim_q.pop_front();
            resetn   = s.rstn;
            inst_ack = s.iack;
            data_ack = s.dack;
            zero     = s.zero;
            opcode   = s.op;
            funct    = s.fn;
            exp_q.push_back(sexp_q.pop_front());
        end
        @(negedge clk);
        #1;
        checking = 1'b0;
    endtask

    initial begin
        int len;
        int fw, dw;
        logic [5:0] op, fn;
        logic [5:0] legal_op[10];
        logic [5:0] rfn[5];
        legal_op = '{6'h00, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00};
        rfn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};

        resetn = 1'b0;
        inst_ack = 1'b1;
        data_ack = 1'b1;
        zero = 1'b1;
        opcode = 6'h23;
        funct = 6'h00;
        #2;
        check("reset_outputs_zero", 32'(act), 32'd0);
        check("reset_state", 32'(state_o), 32'd0);

        // Directed sequence with literal lengths (IF entry to next IF entry).
        gen_reset(2);
        gen_instr(6'h00, 6'h23, 0, 0, 1'b0, len); check("len_subu", len, 4);
        gen_instr(6'h0F, 6'h00, 0, 0, 1'b0, len); check("len_lui", len, 4);
        gen_instr(6'h0D, 6'h11, 0, 0, 1'b0, len); check("len_ori", len, 4);
        gen_instr(6'h09, 6'h3F, 0, 0, 1'b0, len); check("len_addiu", len, 4);
        gen_instr(6'h23, 6'h00, 0, 3, 1'b0, len); check("len_lw_wait3", len, 8);
        gen_instr(6'h04, 6'h00, 0, 0, 1'b1, len); check("len_beq_taken", len, 3);
        gen_instr(6'h04, 6'h00, 0, 0, 1'b0, len); check("len_beq_not", len, 3);
        gen_instr(6'h02, 6'h00, 0, 0, 1'b0, len); check("len_j", len, 3);
        gen_instr(6'h3F, 6'h00, 0, 0, 1'b0, len); check("len_illegal", len, 2);
        gen_instr(6'h2B, 6'h00, 0, 0, 1'b0, len); check("len_sw", len, 4);
        gen_instr(6'h00, 6'h20, 0, 0, 1'b0, len); check("len_bad_funct", len, 2);
        gen_instr(6'h23, 6'h00, 2, 0, 1'b0, len); check("len_lw_fetch2", len, 7);
        run_queue();
        check("first_instret_cycle", first_ret, 5);

        // Randomized instruction stream with random fetch/data wait states.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = legal_op[$urandom_range(0, 9)];
                fn = (op == 6'h00) ? rfn[$urandom_range(0, 4)] : 6'($urandom);
            end
            fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            dw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            gen_instr(op, fn, fw, dw, 1'($urandom_range(0, 1)), len);
        end
        run_queue();

        // Reset asserted mid-fetch, no ack: request must drop without a clock edge.
        begin
            stim_t s;
            out_t e;
            for (int i = 0; i < 3; i++) begin
                s = rnd_stim();
                s.iack = 1'b0;
                e = idle(3'd1);
                e.inst_req = 1'b1;
                push(s, e);
            end
        end
        run_queue();
        check("midfetch_req_before", 32'(inst_req), 32'd1);
        resetn = 1'b0;
        #1;
        check("midfetch_req_drop", 32'(inst_req), 32'd0);
        check("midfetch_state", 32'(state_o), 32'd0);
        check("midfetch_all_zero", 32'(act), 32'd0);

        gen_reset(2);
        gen_instr(6'h02, 6'h00, 1, 0, 1'b0, len);
        gen_instr(6'h00, 6'h2A, 0, 0, 1'b0, len);
        gen_instr(6'h2B, 6'h00, 0, 2, 1'b0, len); check("len_sw_wait2", len, 6);
        run_queue();

        check("retire_count", ret_dut, ret_model);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle sequencing controller for the MIPS-subset core datapath. It steps each instruction through fetch, decode, execute, memory and write-back states. It drives the instruction/data memory request handshakes and configures the datapath per instruction: the immediate-extender mode (`ext_ctr`), ALU operation and source, PC update, register write and write-back select. It sits beside the datapath top and holds no data, only state and decoded class.

## Interface
Parameters: none. Opcode/funct encodings are fixed per MIPS32.

- `clk` in 1: single system clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], valid from ID onward.
- `funct` in 6: IR[5:0], valid from ID onward.
- `zero` in 1: ALU zero flag, valid in EX.
- `inst_req` out 1: instruction fetch request.
- `inst_ack` in 1: fetch complete; instruction word is valid this cycle.
- `data_req` out 1: data memory request.
- `data_wr` out 1: 1 = store, 0 = load; qualified by `data_req`.
- `data_ack` in 1: data access complete; load data is valid this cycle.
- `ir_we` out 1: load IR.
- `pc_we` out 1: write PC.
- `pc_src` out 2: 00 = PC+4, 01 = branch target, 10 = jump target.
- `ext_ctr` out 2: 00 = zero-extend, 01 = sign-extend, 10 = imm<<16.
- `alu_src_imm` out 1: ALU B = extended immediate.
- `alu_op` out 3: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `reg_we` out 1: register file write.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `wb_sel` out 1: 0 = ALU result, 1 = memory data.
- `state_o` out 3: current state encoding, for debug.
- `instret` out 1: one-cycle pulse when an instruction retires.
- `illegal_op` out 1: one-cycle pulse when an unsupported opcode/funct is decoded.

## Operation
- States and encodings: INIT=0, IF=1, ID=2, EX=3, MEM=4, WB=5. The state register and the latched instruction class are the only flops. All outputs are Moore decodes of state plus class, except `inst_ack`/`data_ack`-qualified pulses.
- **INIT**: one cycle after reset release, then go to IF.
- **IF**:
  - Hold `inst_req`=1 until `inst_ack`.
  - In the `inst_ack` cycle: `ir_we`=1, `pc_we`=1, `pc_src`=00; go to ID.
- **ID**:
  - Decode `opcode`/`funct` and latch the class.
  - Classes: RTYPE (op 00; funct 21 addu, 23 subu, 24 and, 25 or, 2A slt), ADDIU 09, ANDI 0C, ORI 0D, LUI 0F, LW 23, SW 2B, BEQ 04, J 02.
  - Anything else: pulse `illegal_op`, go to IF (no retire).
- **EX**: drive `alu_op`, `alu_src_imm` and `ext_ctr` from the class.
  - ADDIU/LW/SW: add, imm, `ext_ctr`=01.
  - ANDI: and, 00. ORI: or, 00. LUI: add, 10 (rs=$0).
  - RTYPE: alu_op from funct, `alu_src_imm`=0.
  - BEQ: sub, 01; `pc_we`=`zero`, `pc_src`=01; retire and go to IF.
  - J: `pc_we`=1, `pc_src`=10; retire and go to IF.
  - LW/SW go to MEM; all others go to WB.
- **MEM**:
  - Hold `data_req`=1 and `data_wr`=(SW) until `data_ack`. Hold `ext_ctr`/`alu_op`/`alu_src_imm` at their EX values so the address stays stable.
  - On ack: SW retires and goes to IF; LW goes to WB.
- **WB**:
  - `reg_we`=1 for one cycle.
  - `reg_dst`=1 only for RTYPE.
  - `wb_sel`=1 only for LW.
  - Retire and go to IF.
- Outside the states listed above, `ext_ctr` defaults to 01, `alu_op` to 000, and all enables to 0.

## Timing
- **Reset**:
  - While `resetn`=0: state=INIT and every output is 0, including `inst_req`, `data_req`, `pc_we` and `reg_we`.
  - Assertion mid-handshake drops the request immediately, with no wait for ack.
  - `inst_req` first rises in the second cycle after release.
- **Acks**: an ack in the same cycle the request first rises is accepted. Acks are ignored when the matching request is 0. The request never drops before its ack.
- **Latency** (zero-wait acks, IF entry to next IF entry):
  - RTYPE/ALU-imm: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/J: 3 cycles.
  - Illegal opcode: 2 cycles.
  - Each wait cycle adds exactly one cycle.
- **instret**: pulses exactly once per retired instruction, in the final cycle of that instruction.
- **No overlap**: `pc_we` and `reg_we` are never asserted in the same cycle; `inst_req` and `data_req` are never asserted together.

## Test plan
- **Reset and R-type**: hold reset, release, `inst_ack` immediate, opcode=00 funct=23 → `inst_req` rises in cycle 2; EX shows `alu_op`=001, `alu_src_imm`=0; WB shows `reg_we`=1, `reg_dst`=1; `instret` at cycle 5 after release.
- **Extender modes**: LUI, ORI, ADDIU in sequence → `ext_ctr` in EX = 10, 00, 01 respectively; `reg_dst`=0 in WB.
- **Load with wait states**: LW with `data_ack` delayed 3 cycles → `data_req`=1 and `data_wr`=0 held for 4 cycles; `ext_ctr`=01 held; WB `wb_sel`=1; total 8 cycles.
- **Branches and jump**: BEQ with `zero`=1, BEQ with `zero`=0, then J → `pc_we` in EX = 1, 0, 1; `pc_src`=01, 01, 10; each takes 3 cycles; no `reg_we`.
- **Illegal opcode**: opcode=3F → `illegal_op` pulses in ID; no `instret`; next `inst_req` follows immediately.
- **Reset mid-fetch**: assert `resetn`=0 while `inst_req`=1 and no ack → `inst_req` drops the same cycle, asynchronously; state_o=0.
